// File: rtl/hp_filter_sequencer_pkg.sv
// Shared types and widths for the high-pass filter channel sequencer.
package hp_filter_sequencer_pkg;

    localparam int SAMPLE_W = 16;
    localparam int CHNUM_W  = 8;
    localparam int FCNT_W   = 16;

    localparam logic [SAMPLE_W-1:0] COEFF_RST = 16'd3000;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        RUN,
        DRAIN
    } seq_state_t;

endpackage

// File: rtl/hp_filter_sequencer_chan_counter.sv
// Modulo-NUM_CH channel counter with optional load-then-advance and a wrap pulse.
module hp_seq_chan_counter
    import hp_filter_sequencer_pkg::*;
#(
    parameter int unsigned NUM_CH = 160
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic [CHNUM_W-1:0] load_val,
    input  logic               inc,
    output logic [CHNUM_W-1:0] count,
    output logic               wrap
);

    localparam logic [CHNUM_W-1:0] LAST = CHNUM_W'(NUM_CH - 1);

    logic [CHNUM_W-1:0] base;
    logic [CHNUM_W-1:0] count_next;

    // A load replaces the current value before the increment, so a resync
    // lands on load_val+1 in a single cycle.
    always_comb begin
        base       = load ? load_val : count;
        count_next = base;
        wrap       = 1'b0;
        if (inc) begin
            if (base >= LAST) begin
                count_next = '0;
                wrap       = 1'b1;
            end else begin
                count_next = base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/hp_filter_sequencer.sv
// Feeds framed samples to a shared filter one channel at a time, tags them,
// distributes the coefficient and checks the filter's output ordering.
module hp_filter_sequencer
    import hp_filter_sequencer_pkg::*;
#(
    parameter int unsigned         NUM_CH    = 160,
    parameter logic [SAMPLE_W-1:0] COEFF_RST = hp_filter_sequencer_pkg::COEFF_RST
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                err_clear,
    input  logic [SAMPLE_W-1:0] src_sample,
    input  logic                src_valid,
    input  logic                src_sof,
    output logic                src_ready,
    input  logic [SAMPLE_W-1:0] coeff_in,
    input  logic                coeff_wr,
    output logic [SAMPLE_W-1:0] chan_in_sample,
    output logic [CHNUM_W-1:0]  chan_in_num,
    output logic                chan_in_valid,
    input  logic                chan_in_read,
    output logic [SAMPLE_W-1:0] coeff,
    input  logic                chan_out_valid,
    input  logic [CHNUM_W-1:0]  chan_out_num,
    output logic                chan_out_read,
    output logic                frame_done,
    output logic [FCNT_W-1:0]   frame_count,
    output logic [1:0]          seq_error,
    output logic                busy
);

    seq_state_t          state, state_next;
    logic [SAMPLE_W-1:0] coeff_shadow;
    logic                src_accept;
    logic                take;
    logic                in_xfer;
    logic                out_xfer;
    logic                out_mismatch;
    logic                ctr_clear;
    logic [CHNUM_W-1:0]  in_count;
    logic [CHNUM_W-1:0]  exp_count;
    logic [CHNUM_W-1:0]  tag;
    logic                in_wrap;
    logic                exp_wrap_unused;
    logic [1:0]          new_err;

    // In SYNC every offered sample is consumed, but only a SOF sample is kept.
    always_comb begin
        src_ready     = ((state == RUN) || (state == SYNC)) && (!chan_in_valid || chan_in_read);
        src_accept    = src_valid && src_ready;
        take          = src_accept && ((state == RUN) || src_sof);
        in_xfer       = chan_in_valid && chan_in_read;
        chan_out_read = (state != IDLE);
        busy          = (state != IDLE);
        out_xfer      = chan_out_valid && chan_out_read;
        out_mismatch  = out_xfer && (chan_out_num != exp_count);
        tag           = src_sof ? '0 : in_count;
        new_err[0]    = take && ((src_sof && (in_count != '0))
                               || (!src_sof && (in_count == '0) && (state == RUN)));
        new_err[1]    = out_mismatch;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = SYNC;
            SYNC: begin
                if (take)         state_next = RUN;
                else if (!enable) state_next = IDLE;
            end
            RUN:     if (!enable) state_next = DRAIN;
            DRAIN:   if (!chan_in_valid || chan_in_read) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        ctr_clear = (state_next == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    hp_seq_chan_counter #(.NUM_CH(NUM_CH)) u_in_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (ctr_clear),
        .load     (take && src_sof),
        .load_val ('0),
        .inc      (take),
        .count    (in_count),
        .wrap     (in_wrap)
    );

    hp_seq_chan_counter #(.NUM_CH(NUM_CH)) u_exp_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (ctr_clear),
        .load     (out_mismatch),
        .load_val (chan_out_num),
        .inc      (out_xfer),
        .count    (exp_count),
        .wrap     (exp_wrap_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            chan_in_valid  <= 1'b0;
            chan_in_sample <= '0;
            chan_in_num    <= '0;
        end else if (take) begin
            chan_in_valid  <= 1'b1;
            chan_in_sample <= src_sample;
            chan_in_num    <= tag;
        end else if (in_xfer) begin
            chan_in_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done  <= 1'b0;
            frame_count <= '0;
            seq_error   <= '0;
        end else begin
            frame_done <= in_wrap;
            if (in_wrap) frame_count <= frame_count + 1'b1;
            seq_error <= (err_clear ? 2'b00 : seq_error) | new_err;
        end
    end

    // Coefficient changes only at a frame boundary so a frame is filtered
    // with one coefficient; a write in the boundary cycle takes effect at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            coeff_shadow <= COEFF_RST;
            coeff        <= COEFF_RST;
        end else begin
            if (coeff_wr) coeff_shadow <= coeff_in;
            if ((state == IDLE) || (take && (tag == '0)))
                coeff <= coeff_wr ? coeff_in : coeff_shadow;
        end
    end

endmodule

// File: tb/tb_hp_filter_sequencer.sv
// Directed bench for hp_filter_sequencer with hand-computed expectations.
module tb_hp_filter_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        err_clear;
    logic [15:0] src_sample;
    logic        src_valid;
    logic        src_sof;
    logic        src_ready;
    logic [15:0] coeff_in;
    logic        coeff_wr;
    logic [15:0] chan_in_sample;
    logic [7:0]  chan_in_num;
    logic        chan_in_valid;
    logic        chan_in_read;
    logic [15:0] coeff;
    logic        chan_out_valid;
    logic [7:0]  chan_out_num;
    logic        chan_out_read;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [1:0]  seq_error;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    hp_filter_sequencer #(.NUM_CH(160), .COEFF_RST(16'd3000)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .err_clear      (err_clear),
        .src_sample     (src_sample),
        .src_valid      (src_valid),
        .src_sof        (src_sof),
        .src_ready      (src_ready),
        .coeff_in       (coeff_in),
        .coeff_wr       (coeff_wr),
        .chan_in_sample (chan_in_sample),
        .chan_in_num    (chan_in_num),
        .chan_in_valid  (chan_in_valid),
        .chan_in_read   (chan_in_read),
        .coeff          (coeff),
        .chan_out_valid (chan_out_valid),
        .chan_out_num   (chan_out_num),
        .chan_out_read  (chan_out_read),
        .frame_done     (frame_done),
        .frame_count    (frame_count),
        .seq_error      (seq_error),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sample offered with chan_in_read high; it must appear tagged next cycle.
    task automatic send(input logic [15:0] data, input logic sof, input logic [7:0] exp_num);
        src_valid    = 1'b1;
        src_sample   = data;
        src_sof      = sof;
        chan_in_read = 1'b1;
        #1 chk("src_ready", src_ready, 1);
        tick();
        chk("in_valid", chan_in_valid, 1);
        chk("in_num", chan_in_num, exp_num);
        chk("in_sample", chan_in_sample, data);
        src_valid = 1'b0;
        src_sof   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; err_clear = 1'b0;
        src_sample = '0; src_valid = 1'b0; src_sof = 1'b0;
        coeff_in = '0; coeff_wr = 1'b0; chan_in_read = 1'b0;
        chan_out_valid = 1'b0; chan_out_num = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_in_valid", chan_in_valid, 0);
        chk("rst_out_read", chan_out_read, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_seq_error", seq_error, 0);
        chk("rst_coeff", coeff, 3000);
        chk("rst_in_num", chan_in_num, 0);
        chk("rst_in_sample", chan_in_sample, 0);

        // Two full frames; a non-SOF sample in SYNC is dropped first.
        enable = 1'b1;
        tick();
        chk("sync_busy", busy, 1);
        chk("sync_out_read", chan_out_read, 1);
        src_valid = 1'b1; src_sof = 1'b0; src_sample = 16'hDEAD; chan_in_read = 1'b1;
        #1 chk("sync_src_ready", src_ready, 1);
        tick();
        src_valid = 1'b0;
        chk("sync_discard", chan_in_valid, 0);
        for (int i = 0; i < 320; i++) begin
            send(16'h1000 + 16'(i), (i % 160) == 0, 8'(i % 160));
            chk("frame_done", frame_done, ((i % 160) == 159) ? 1 : 0);
        end
        tick();
        chk("stream_idle_valid", chan_in_valid, 0);
        chk("frame_count_2", frame_count, 2);
        chk("stream_seq_error", seq_error, 0);

        // Stall at channel 37 for five cycles.
        for (int ch = 0; ch <= 37; ch++) send(16'h2000 + 16'(ch), ch == 0, 8'(ch));
        chan_in_read = 1'b0; src_valid = 1'b1; src_sample = 16'h2026;
        repeat (5) begin
            #1 chk("stall_src_ready", src_ready, 0);
            tick();
            chk("stall_valid", chan_in_valid, 1);
            chk("stall_num", chan_in_num, 37);
            chk("stall_sample", chan_in_sample, 16'h2025);
        end
        for (int ch = 38; ch < 80; ch++) send(16'h2000 + 16'(ch), 1'b0, 8'(ch));

        // Early SOF at channel 80, then err_clear, then clear colliding with a new error.
        send(16'h3000, 1'b1, 8'd0);
        chk("early_sof_err", seq_error, 1);
        send(16'h3001, 1'b0, 8'd1);
        send(16'h3002, 1'b0, 8'd2);
        chk("err_sticky", seq_error, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("err_cleared", seq_error, 0);
        err_clear = 1'b1;
        send(16'h3003, 1'b1, 8'd0);
        err_clear = 1'b0;
        chk("err_wins_clear", seq_error, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("err_cleared_2", seq_error, 0);

        // Missing SOF at channel 0: flagged, still tagged 0.
        for (int ch = 1; ch < 160; ch++) send(16'h3000 + 16'(ch), 1'b0, 8'(ch));
        send(16'h3100, 1'b0, 8'd0);
        chk("missing_sof_err", seq_error, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // Coefficient write mid-frame, then a write coinciding with channel 0.
        for (int ch = 1; ch < 50; ch++) send(16'h4000 + 16'(ch), 1'b0, 8'(ch));
        coeff_wr = 1'b1; coeff_in = 16'd1234;
        send(16'h4032, 1'b0, 8'd50);
        coeff_wr = 1'b0;
        chk("coeff_held_wr", coeff, 3000);
        for (int ch = 51; ch < 160; ch++) send(16'h4000 + 16'(ch), 1'b0, 8'(ch));
        chk("coeff_held_eof", coeff, 3000);
        send(16'h4100, 1'b1, 8'd0);
        chk("coeff_applied", coeff, 1234);
        for (int ch = 1; ch < 160; ch++) send(16'h4100 + 16'(ch), 1'b0, 8'(ch));
        coeff_wr = 1'b1; coeff_in = 16'd555;
        send(16'h4200, 1'b1, 8'd0);
        coeff_wr = 1'b0;
        chk("coeff_same_cycle", coeff, 555);
        chk("frame_count_5", frame_count, 5);
        tick();

        // Filter output ordering: 0..3 fine, 5 out of order, 6/7 fine, 9 out of order.
        for (int n = 0; n < 4; n++) begin
            chan_out_valid = 1'b1; chan_out_num = 8'(n);
            tick();
            chk("out_in_order", seq_error, 0);
        end
        chan_out_num = 8'd5;
        tick();
        chk("out_skip_err", seq_error, 2);
        chan_out_valid = 1'b0; err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("out_err_cleared", seq_error, 0);
        chan_out_valid = 1'b1; chan_out_num = 8'd6;
        tick();
        chk("out_resync_6", seq_error, 0);
        chan_out_num = 8'd7;
        tick();
        chk("out_resync_7", seq_error, 0);
        chan_out_num = 8'd9;
        tick();
        chk("out_skip_err_2", seq_error, 2);
        chan_out_valid = 1'b0; err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // Drain: disable with a held sample and the filter stalled.
        src_valid = 1'b1; src_sof = 1'b0; src_sample = 16'h7001; chan_in_read = 1'b0;
        #1 chk("drain_pre_ready", src_ready, 1);
        tick();
        src_valid = 1'b0; enable = 1'b0;
        chk("drain_held_num", chan_in_num, 1);
        repeat (3) begin
            tick();
            chk("drain_busy", busy, 1);
            chk("drain_valid", chan_in_valid, 1);
            chk("drain_src_ready", src_ready, 0);
        end
        chan_in_read = 1'b1;
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_valid", chan_in_valid, 0);
        chk("idle_out_read", chan_out_read, 0);
        chk("idle_frame_count", frame_count, 5);
        enable = 1'b1;
        tick();
        chan_out_valid = 1'b1; chan_out_num = 8'd0;
        send(16'h7100, 1'b1, 8'd0);
        chan_out_valid = 1'b0;
        send(16'h7101, 1'b0, 8'd1);
        chk("counters_zeroed", seq_error, 0);

        // Reset while a sample is held.
        chan_in_read = 1'b0; src_valid = 1'b1; src_sample = 16'h7102;
        tick();
        src_valid = 1'b0;
        chk("pre_reset_valid", chan_in_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0; enable = 1'b0; chan_in_read = 1'b1;
        chk("mid_reset_valid", chan_in_valid, 0);
        chk("mid_reset_num", chan_in_num, 0);
        chk("mid_reset_coeff", coeff, 3000);
        chk("mid_reset_fcount", frame_count, 0);
        chk("mid_reset_busy", busy, 0);
        tick();
        chk("post_reset_valid", chan_in_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hp_filter_sequencer.md
HP_FILTER_SEQUENCER -- requirements
Module: hp_filter_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 160, channels per frame (range 1..256).
REQ-002 SHALL have parameter COEFF_RST, default 16'd3000, filter coefficient after reset.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports enable in 1 (run); err_clear in 1 (clear sticky errors).
REQ-006 SHALL have ports src_sample in 16; src_valid in 1; src_sof in 1 (sample is channel 0); src_ready out 1.
REQ-007 SHALL have ports coeff_in in 16; coeff_wr in 1 (coefficient write strobe).
REQ-008 SHALL have filter-side ports chan_in_sample out 16; chan_in_num out 8; chan_in_valid out 1; chan_in_read in 1; coeff out 16.
REQ-009 SHALL have filter-output ports chan_out_valid in 1; chan_out_num in 8; chan_out_read out 1.
REQ-010 SHALL have status ports frame_done out 1 (pulse); frame_count out 16; seq_error out 2 (sticky); busy out 1.

Function
REQ-011 SHALL implement FSM states IDLE, SYNC, RUN, DRAIN.
REQ-012 IDLE->SYNC when enable=1; SYNC->RUN on accepted src sample with src_sof=1; RUN->DRAIN when enable=0; DRAIN->IDLE once hold register empty.
REQ-013 In SYNC, src_ready=1 and samples with src_sof=0 SHALL be discarded.
REQ-014 One-entry hold register; src accept = src_valid & src_ready; src_ready = (state==RUN | SYNC-accept-of-SOF) & (!hold_valid | chan_in_read).
REQ-015 Accepted sample SHALL appear on chan_in_sample/chan_in_num with chan_in_valid=1 the following cycle (latency 1).
REQ-016 chan_in_valid/sample/num SHALL stay stable until chan_in_read=1; transfer = chan_in_valid & chan_in_read; back-to-back transfers at 1/cycle.
REQ-017 Channel counter SHALL tag each accepted sample, incrementing per accept, wrapping NUM_CH-1 -> 0.
REQ-018 Accept with counter wrapping to 0: frame_done pulses 1 cycle; frame_count increments, wrapping 65535 -> 0.
REQ-019 src_sof=1 with counter!=0: seq_error[0] set; sample tagged channel 0; counter resyncs to 1.
REQ-020 src_sof=0 with counter==0 in RUN: seq_error[0] set; sample still tagged 0.
REQ-021 coeff_wr SHALL latch coeff_in into a shadow register; shadow copied to coeff on the channel-0 accept or immediately in IDLE; same-cycle coeff_wr and channel-0 accept: new coeff_in applied.
REQ-022 chan_out_read SHALL equal (state!=IDLE).
REQ-023 Expected-output counter SHALL advance mod NUM_CH on each chan_out_valid & chan_out_read; chan_out_num mismatch sets seq_error[1] and resyncs expected to chan_out_num+1.
REQ-024 err_clear SHALL zero seq_error, lower priority than same-cycle new error (error wins).
REQ-025 busy SHALL be 1 in all states except IDLE.
REQ-026 Entering IDLE SHALL zero channel and expected counters; frame_count retained.

Reset
REQ-027 On reset: state IDLE; chan_in_valid, src_ready, chan_out_read, frame_done, busy = 0; chan_in_sample, chan_in_num, frame_count, seq_error, counters = 0; coeff and shadow = COEFF_RST.
REQ-028 Reset mid-transfer SHALL drop the held sample without completing the handshake.

Structure
REQ-029 Shared package SHALL hold state enum, SAMPLE_W=16, CHNUM_W=8, FCNT_W=16, COEFF_RST.
REQ-030 Sub-module hp_seq_chan_counter (mod-NUM_CH counter with load/wrap pulse), instanced twice (input tag, output check).

Verification
REQ-031 Enable, 320 samples, SOF every 160th, chan_in_read=1 -> chan_in_num 0..159 twice, frame_done 2 pulses, frame_count=2, seq_error=0.
REQ-032 chan_in_read low 5 cycles mid-frame at channel 37 -> sample/num held, src_ready=0, no sample lost or duplicated.
REQ-033 SOF at channel 80 -> seq_error=2'b01, next tags 0,1,2; err_clear -> seq_error=0.
REQ-034 coeff_wr 1234 at channel 50 -> coeff stays 3000 until next channel-0 accept, then 1234.
REQ-035 Filter returns num 5 when 4 expected -> seq_error[1]=1, next expected 6.
REQ-036 enable drop with held sample, chan_in_read low 3 cycles -> DRAIN until transfer, then IDLE, busy=0, counters 0.
